// File: rtl/ram_bit_serializer_pkg.sv
// Shared TX-path definitions: FSM encoding, byte width and the default RAM address width.
package ram_bit_serializer_pkg;

    localparam int BYTE_WIDTH            = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_bit_serializer.sv
// Walks a byte range of the packet RAM and streams it out LSB-first over a
// valid/ready bit interface, pulsing done once the final bit has been accepted.
module ram_bit_serializer
    import ram_bit_serializer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = BYTE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_WIDTH:0]   num_bytes,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic                     bit_out,
    output logic                     bit_valid,
    input  logic                     bit_ready,
    output logic                     last_bit,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic hs;
    logic byte_end;
    logic rem_zero;

    assign hs       = (state_q == ST_SHIFT) && bit_ready;
    assign byte_end = (cnt_q == CNT_LAST);
    assign rem_zero = (rem_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Datapath only matters while a transfer is active, so it carries no reset.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_bytes == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (hs && byte_end && rem_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (num_bytes != '0)) begin
                    addr_d = base_address;
                    rem_d  = num_bytes;
                end
            end
            ST_FETCH: begin
                shift_d = read_data;
                cnt_d   = '0;
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
            end
            ST_SHIFT: begin
                if (hs) begin
                    if (!byte_end) begin
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (!rem_zero) begin
                        // Back-to-back bytes: next word is already on read_data.
                        shift_d = read_data;
                        cnt_d   = '0;
                        addr_d  = addr_q + 1'b1;
                        rem_d   = rem_q - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        read_address = addr_q;
        bit_valid    = (state_q == ST_SHIFT);
        bit_out      = bit_valid && shift_q[0];
        last_bit     = bit_valid && rem_zero && byte_end;
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
    end

endmodule
